// File: rtl/memory_wb_pkg.sv
// Shared definitions for the memory/writeback stage: FSM states, writeback
// source codes, default timeout and the access legality helper.
package memory_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HALT   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_SLBI = 2'b11
  } wb_sel_t;

  localparam int DEFAULT_TIMEOUT = 64;
  localparam int DEFAULT_DATA_W  = 16;

  // Odd addresses and simultaneous load+store are both unserviceable.
  function automatic logic bad_access(input logic addr_lsb, input logic rd, input logic wr);
    return addr_lsb | (rd & wr);
  endfunction

endpackage

// File: rtl/memory_wb_if.sv
// Data-memory bus between the memory/writeback stage (master) and the
// memory (slave): one-cycle request pulse, multi-cycle done handshake.
interface memory_wb_if
  import memory_wb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              mem_busy;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_done, mem_busy
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_done, mem_busy
  );

endinterface

// File: rtl/memory_wb_wb_sel_mux.sv
// 4:1 register-file writeback source selector.
module wb_sel_mux
  import memory_wb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] alu_val,
  input  logic [DATA_W-1:0] mem_val,
  input  logic [DATA_W-1:0] link_val,
  input  logic [DATA_W-1:0] slbi_val,
  output logic [DATA_W-1:0] wdata
);

  always_comb begin
    wdata = alu_val;
    case (sel)
      WB_ALU:  wdata = alu_val;
      WB_MEM:  wdata = mem_val;
      WB_LINK: wdata = link_val;
      WB_SLBI: wdata = slbi_val;
      default: wdata = alu_val;
    endcase
  end

endmodule

// File: rtl/memory_wb.sv
// Memory-access / writeback stage: retires ALU ops in the same cycle, runs the
// request/done handshake for loads and stores, and holds sticky halt/error.
module memory_wb
  import memory_wb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] Out0,
  input  logic [DATA_W-1:0] Out3,
  input  logic [DATA_W-1:0] PCwb,
  input  logic [DATA_W-1:0] WrData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        WbSel,
  input  logic              RegWrite,
  input  logic [2:0]        WrReg,
  input  logic              Halt,
  memory_wb_if.master       mem,
  output logic              Stall,
  output logic [DATA_W-1:0] pc_next,
  output logic              pc_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [2:0]        rf_wsel,
  output logic              rf_we,
  output logic              halted,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] addr_q, wdata_q, pc_q;
  logic              is_wr_q, regwr_q;
  logic [1:0]        wbsel_q;
  logic [2:0]        wrreg_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              latch_en, cnt_clr, cnt_inc;
  logic              stall_c, pc_we_c, rf_we_c, rd_c, wr_c;
  logic [1:0]        mux_sel;
  logic [DATA_W-1:0] mux_alu, mux_mem, mux_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      is_wr_q <= 1'b0;
      regwr_q <= 1'b0;
      wbsel_q <= 2'b00;
      wrreg_q <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_q  <= ALUOut;
        wdata_q <= WrData;
        pc_q    <= PCwb;
        is_wr_q <= MemWrite;
        regwr_q <= RegWrite;
        wbsel_q <= WbSel;
        wrreg_q <= WrReg;
      end
      if (cnt_clr)
        cnt_q <= '0;
      else if (cnt_inc && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Retirement is Mealy: an ALU op commits in its IDLE cycle, a memory op in
  // the cycle mem_done is seen, using the request registers captured at accept.
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    stall_c  = 1'b0;
    pc_we_c  = 1'b0;
    rf_we_c  = 1'b0;
    rd_c     = 1'b0;
    wr_c     = 1'b0;
    mux_sel  = WbSel;
    mux_alu  = ALUOut;
    mux_mem  = '0;
    pc_next  = PCwb;
    rf_wsel  = WrReg;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (Halt) begin
            stall_c = 1'b1;
            state_d = ST_HALT;
          end else if (MemRead || MemWrite) begin
            stall_c = 1'b1;
            if (bad_access(ALUOut[0], MemRead, MemWrite))
              state_d = ST_ERR;
            else if (!mem.mem_busy) begin
              latch_en = 1'b1;
              state_d  = ST_ACCESS;
            end
          end else begin
            rf_we_c = RegWrite;
            pc_we_c = 1'b1;
          end
        end
      end

      ST_ACCESS, ST_WAIT: begin
        if (state_q == ST_ACCESS) begin
          rd_c    = ~is_wr_q;
          wr_c    = is_wr_q;
          cnt_clr = 1'b1;
        end
        mux_sel = wbsel_q;
        mux_alu = addr_q;
        mux_mem = mem.mem_rdata;
        pc_next = pc_q;
        rf_wsel = wrreg_q;
        if (mem.mem_done) begin
          rf_we_c = regwr_q;
          pc_we_c = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          if (state_q == ST_ACCESS)
            state_d = ST_WAIT;
          else if (cnt_q == CNT_LAST)
            state_d = ST_ERR;
          else
            cnt_inc = 1'b1;
        end
      end

      ST_HALT, ST_ERR: stall_c = 1'b1;

      default: state_d = ST_IDLE;
    endcase
  end

  wb_sel_mux #(.DATA_W(DATA_W)) u_wb_sel_mux (
    .sel      (mux_sel),
    .alu_val  (mux_alu),
    .mem_val  (mux_mem),
    .link_val (Out0),
    .slbi_val (Out3),
    .wdata    (mux_out)
  );

  // Control outputs are forced low for as long as reset is held.
  always_comb begin
    rf_wdata      = mux_out;
    mem.mem_addr  = addr_q;
    mem.mem_wdata = wdata_q;
    mem.mem_rd    = rst_n & rd_c;
    mem.mem_wr    = rst_n & wr_c;
    Stall         = rst_n & stall_c;
    pc_we         = rst_n & pc_we_c;
    rf_we         = rst_n & rf_we_c;
    halted        = rst_n & (state_q == ST_HALT);
    err           = rst_n & (state_q == ST_ERR);
  end

endmodule

// File: tb/tb_memory_wb.sv
// Randomized scoreboard bench for memory_wb with directed reset, timeout,
// misalignment and halt scenarios.
`timescale 1ns/1ps
module tb_memory_wb;
  import memory_wb_pkg::*;

  localparam int TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, MemRead, MemWrite, RegWrite, Halt;
  logic [15:0] ALUOut, Out0, Out3, PCwb, WrData;
  logic [1:0]  WbSel;
  logic [2:0]  WrReg;
  logic        Stall, pc_we, rf_we, halted, err;
  logic [15:0] pc_next, rf_wdata;
  logic [2:0]  rf_wsel;

  always #5 clk = ~clk;

  memory_wb_if #(.DATA_W(16)) mem_bus ();

  memory_wb #(.TIMEOUT(TB_TIMEOUT), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ALUOut(ALUOut), .Out0(Out0),
    .Out3(Out3), .PCwb(PCwb), .WrData(WrData), .MemRead(MemRead), .MemWrite(MemWrite),
    .WbSel(WbSel), .RegWrite(RegWrite), .WrReg(WrReg), .Halt(Halt), .mem(mem_bus),
    .Stall(Stall), .pc_next(pc_next), .pc_we(pc_we), .rf_wdata(rf_wdata),
    .rf_wsel(rf_wsel), .rf_we(rf_we), .halted(halted), .err(err)
  );

  typedef struct {
    logic rd; logic wr; logic [1:0] wbsel; logic [15:0] alu; logic [15:0] out0;
    logic [15:0] out3; logic [15:0] pc; logic [15:0] wrdata; logic regwr;
    logic [2:0] wrreg; logic halt; int busy;
  } op_t;
  typedef struct { logic rf_we; logic [2:0] wsel; logic [15:0] wdata; logic [15:0] pc; } retire_t;
  typedef struct { logic is_wr; logic [15:0] addr; logic [15:0] wdata; } req_t;

  retire_t     exp_retire[$];
  req_t        exp_req[$];
  logic [15:0] model_mem [int unsigned];
  logic [15:0] resp_mem  [int unsigned];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          mon_en = 0;
  bit          no_done = 0;
  bit          late_go = 0;
  int          fixed_lat = -1;
  logic        prev_busy = 1'b0;

  function automatic logic [15:0] mem_init(input logic [15:0] a);
    return {a[7:0] ^ 8'h3C, ~a[15:8]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic print_summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  task automatic drive_op(input op_t op);
    ex_valid = 1'b1; MemRead = op.rd; MemWrite = op.wr; WbSel = op.wbsel;
    ALUOut = op.alu; Out0 = op.out0; Out3 = op.out3; PCwb = op.pc;
    WrData = op.wrdata; RegWrite = op.regwr; WrReg = op.wrreg; Halt = op.halt;
  endtask

  // Reference: the instruction's architectural effect, independent of timing.
  task automatic apply_stimulus(input op_t op);
    retire_t     e;
    req_t        r;
    logic [15:0] rd_val;
    int          cyc;
    rd_val = 16'h0000;
    if (op.rd)
      rd_val = model_mem.exists(op.alu) ? model_mem[op.alu] : mem_init(op.alu);
    if (op.wr)
      model_mem[op.alu] = op.wrdata;
    e.pc = op.pc; e.wsel = op.wrreg; e.rf_we = op.regwr;
    case (op.wbsel)
      2'b00:   e.wdata = op.alu;
      2'b01:   e.wdata = rd_val;
      2'b10:   e.wdata = op.out0;
      default: e.wdata = op.out3;
    endcase
    if (op.rd || op.wr) begin
      r.is_wr = op.wr; r.addr = op.alu; r.wdata = op.wrdata;
      exp_req.push_back(r);
    end
    exp_retire.push_back(e);
    drive_op(op);
    mem_bus.mem_busy = (op.busy > 0);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!Stall) break;
      @(posedge clk); #1;
      cyc++;
      if (cyc >= op.busy) mem_bus.mem_busy = 1'b0;
      if (cyc > 200) begin
        check_output("retire_timeout", 32'd0, 32'd1);
        print_summary();
        $finish;
      end
    end
    @(posedge clk); #1;
    mem_bus.mem_busy = 1'b0;
    ex_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    ex_valid = 1'b0; Halt = 1'b0;
    ALUOut = 16'($urandom); PCwb = 16'($urandom);
    MemRead = 1'($urandom); MemWrite = 1'($urandom); RegWrite = 1'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0; ex_valid = 1'b0; Halt = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_request();
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mem_bus.mem_rd || mem_bus.mem_wr) && cyc < 20);
    check_output("request_seen", 32'(mem_bus.mem_rd | mem_bus.mem_wr), 32'd1);
  endtask

  // Memory responder: answers each request after a random (or forced) delay.
  task automatic serve_request(input logic is_wr, input logic [15:0] a, input logic [15:0] wd);
    int lat;
    lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
    if (is_wr) resp_mem[a] = wd;
    if (no_done) begin
      wait (late_go || !rst_n);
      if (!rst_n) return;
      lat = 1;
    end
    repeat (lat) @(posedge clk);
    #1;
    mem_bus.mem_done  = 1'b1;
    mem_bus.mem_rdata = resp_mem.exists(a) ? resp_mem[a] : mem_init(a);
    @(posedge clk); #1;
    mem_bus.mem_done  = 1'b0;
    mem_bus.mem_rdata = 16'($urandom);
  endtask

  initial begin
    mem_bus.mem_done = 1'b0;
    mem_bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && (mem_bus.mem_rd || mem_bus.mem_wr))
        serve_request(mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_wdata);
    end
  end

  // Monitor: pops expected requests and retirements as the DUT presents them.
  always @(negedge clk) begin
    req_t    r;
    retire_t e;
    if (mon_en) begin
      if (mem_bus.mem_rd || mem_bus.mem_wr) begin
        if (prev_busy) check_output("request_while_busy", 32'd1, 32'd0);
        if (exp_req.size() == 0) check_output("unexpected_request", 32'd1, 32'd0);
        else begin
          r = exp_req.pop_front();
          check_output("req_kind", {30'd0, mem_bus.mem_rd, mem_bus.mem_wr}, r.is_wr ? 32'd1 : 32'd2);
          check_output("mem_addr", 32'(mem_bus.mem_addr), 32'(r.addr));
          if (r.is_wr) check_output("mem_wdata", 32'(mem_bus.mem_wdata), 32'(r.wdata));
        end
      end
      if (pc_we) begin
        if (exp_retire.size() == 0) check_output("unexpected_retire", 32'd1, 32'd0);
        else begin
          e = exp_retire.pop_front();
          check_output("pc_next", 32'(pc_next), 32'(e.pc));
          check_output("rf_we", 32'(rf_we), 32'(e.rf_we));
          if (e.rf_we) begin
            check_output("rf_wsel", 32'(rf_wsel), 32'(e.wsel));
            check_output("rf_wdata", 32'(rf_wdata), 32'(e.wdata));
          end
        end
      end else if (rf_we) check_output("rf_we_without_pc_we", 32'd1, 32'd0);
      check_output("stall", 32'(Stall), 32'(ex_valid & ~pc_we));
      check_output("halt_err_clear", {30'd0, halted, err}, 32'd0);
    end
    prev_busy <= mem_bus.mem_busy;
  end

  initial begin
    #2_000_000;
    check_output("watchdog", 32'd0, 32'd1);
    print_summary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    op_t op;
    int  kind;
    mem_bus.mem_busy = 1'b0;
    op = '{rd:0, wr:0, wbsel:2'b00, alu:16'h1234, out0:16'h0, out3:16'h0, pc:16'h0010,
           wrdata:16'h0, regwr:1, wrreg:3'd3, halt:0, busy:0};
    drive_op(op);
    #2;
    check_output("reset_mem_rd", 32'(mem_bus.mem_rd), 32'd0);
    check_output("reset_mem_wr", 32'(mem_bus.mem_wr), 32'd0);
    check_output("reset_rf_we", 32'(rf_we), 32'd0);
    check_output("reset_pc_we", 32'(pc_we), 32'd0);
    check_output("reset_stall", 32'(Stall), 32'd0);
    check_output("reset_halted_err", {30'd0, halted, err}, 32'd0);
    ex_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;

    $display("[TB] directed ADD, load, store");
    apply_stimulus(op);
    model_mem[32'h0040] = 16'hBEEF; resp_mem[32'h0040] = 16'hBEEF;
    fixed_lat = 3;
    op = '{rd:1, wr:0, wbsel:2'b01, alu:16'h0040, out0:16'h1111, out3:16'h2222, pc:16'h0012,
           wrdata:16'h0, regwr:1, wrreg:3'd5, halt:0, busy:0};
    apply_stimulus(op);
    fixed_lat = -1;
    op = '{rd:0, wr:1, wbsel:2'b00, alu:16'h0100, out0:16'h0, out3:16'h0, pc:16'h0014,
           wrdata:16'hA5A5, regwr:0, wrreg:3'd1, halt:0, busy:2};
    apply_stimulus(op);

    $display("[TB] random traffic");
    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 9));
      op.out0 = 16'($urandom); op.out3 = 16'($urandom); op.pc = 16'($urandom);
      op.wrdata = 16'($urandom); op.wrreg = 3'($urandom); op.halt = 0;
      if (kind < 5) begin
        op.rd = 0; op.wr = 0; op.alu = 16'($urandom); op.wbsel = 2'($urandom);
        op.regwr = 1'($urandom); op.busy = 0;
      end else begin
        op.rd = (kind < 8); op.wr = (kind >= 8);
        op.alu = 16'h0200 + 16'(int'($urandom_range(0, 15)) * 2);
        op.wbsel = op.rd ? 2'b01 : 2'($urandom);
        op.regwr = op.rd ? 1'($urandom) : 1'b0;
        op.busy = int'($urandom_range(0, 3));
      end
      apply_stimulus(op);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end
    idle_cycles(3);
    check_output("retire_queue_drained", 32'(exp_retire.size()), 32'd0);
    check_output("request_queue_drained", 32'(exp_req.size()), 32'd0);

    $display("[TB] reset during WAIT");
    mon_en = 0; no_done = 1;
    op = '{rd:1, wr:0, wbsel:2'b01, alu:16'h0080, out0:16'h0, out3:16'h0, pc:16'h0100,
           wrdata:16'h0, regwr:1, wrreg:3'd2, halt:0, busy:0};
    drive_op(op);
    wait_request();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_output("midwait_reset_mem_rd", 32'(mem_bus.mem_rd), 32'd0);
    check_output("midwait_reset_mem_wr", 32'(mem_bus.mem_wr), 32'd0);
    check_output("midwait_reset_stall", 32'(Stall), 32'd0);
    check_output("midwait_reset_halted_err", {30'd0, halted, err}, 32'd0);
    ex_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; no_done = 0;
    @(posedge clk); #1;
    mon_en = 1;
    op.pc = 16'h0102;
    apply_stimulus(op);

    $display("[TB] timeout");
    mon_en = 0; no_done = 1;
    reset_pulse();
    op.alu = 16'h0090; op.pc = 16'h0200;
    drive_op(op);
    wait_request();
    for (int k = 0; k < TB_TIMEOUT; k++) begin
      @(negedge clk);
      check_output("err_low_during_wait", 32'(err), 32'd0);
    end
    @(negedge clk);
    check_output("err_after_timeout", 32'(err), 32'd1);
    check_output("stall_in_err", 32'(Stall), 32'd1);
    late_go = 1;
    @(negedge clk);
    check_output("late_done_pc_we", 32'(pc_we), 32'd0);
    check_output("late_done_rf_we", 32'(rf_we), 32'd0);
    check_output("late_done_err_sticky", 32'(err), 32'd1);
    repeat (2) @(negedge clk);
    check_output("err_still_sticky", 32'(err), 32'd1);
    late_go = 0; no_done = 0;

    $display("[TB] misaligned load");
    reset_pulse();
    op.alu = 16'h0041; op.pc = 16'h0300;
    drive_op(op);
    @(negedge clk);
    check_output("misaligned_stall", 32'(Stall), 32'd1);
    check_output("misaligned_no_rd", 32'(mem_bus.mem_rd), 32'd0);
    check_output("misaligned_pc_we", 32'(pc_we), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("misaligned_err", 32'(err), 32'd1);
      check_output("misaligned_err_stall", 32'(Stall), 32'd1);
      check_output("misaligned_err_quiet", {29'd0, pc_we, rf_we, mem_bus.mem_rd}, 32'd0);
    end

    $display("[TB] halt");
    reset_pulse();
    op = '{rd:0, wr:1, wbsel:2'b00, alu:16'h0100, out0:16'h0, out3:16'h0, pc:16'h0400,
           wrdata:16'h5555, regwr:1, wrreg:3'd4, halt:1, busy:0};
    drive_op(op);
    @(negedge clk);
    check_output("halt_cycle_writes", {29'd0, pc_we, rf_we, mem_bus.mem_wr}, 32'd0);
    check_output("halt_cycle_halted", 32'(halted), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("halted", 32'(halted), 32'd1);
      check_output("halted_stall", 32'(Stall), 32'd1);
      check_output("halted_quiet", {28'd0, pc_we, rf_we, mem_bus.mem_wr, err}, 32'd0);
    end

    ex_valid = 1'b0;
    print_summary();
    $finish;
  end

endmodule
